// File: rtl/ycbcr_to_rgb.sv
// Full-range BT.601 YCbCr to RGB, three-stage pipeline with
// frame-latched display mode and delayed syncs.
module ycbcr_to_rgb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_sel,
  input  logic [7:0] yi,
  input  logic [7:0] cbi,
  input  logic [7:0] cri,
  input  logic       vi,
  input  logic       hsi,
  input  logic       vsi,
  output logic [7:0] ro,
  output logic [7:0] go,
  output logic [7:0] bo,
  output logic       vo,
  output logic       hso,
  output logic       vso
);

  typedef struct packed {
    logic       v;
    logic       hs;
    logic       vs;
    logic [1:0] m;
  } ctl_t;

  logic [1:0] mode_act;
  logic       vs_prev;

  logic [7:0]        y1;
  logic signed [8:0] dcb1, dcr1;
  ctl_t              c1;

  logic [7:0]         y2;
  logic signed [19:0] ys2, pr2, pg2, pb2;
  ctl_t               c2;

  logic signed [19:0] cbx, crx;
  logic signed [19:0] sr, sg, sb;
  logic [7:0]         cr_r, cr_g, cr_b;
  logic [7:0]         mr, mg, mb;

  function automatic logic [7:0] clamp(
    input logic signed [19:0] s
  );
    if (s[19])
      return 8'd0;
    else if (|s[18:8])
      return 8'd255;
    else
      return s[7:0];
  endfunction

  // Edge-only capture keeps the mode fixed for a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_act <= 2'b00;
      vs_prev  <= 1'b0;
    end else begin
      vs_prev <= vsi;
      if (vsi && !vs_prev)
        mode_act <= mode_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1   <= '0;
      dcb1 <= '0;
      dcr1 <= '0;
      c1   <= '0;
    end else begin
      y1   <= yi;
      dcb1 <= $signed({1'b0, cbi}) - 9'sd128;
      dcr1 <= $signed({1'b0, cri}) - 9'sd128;
      c1   <= '{v: vi, hs: hsi, vs: vsi,
                m: mode_act};
    end
  end

  assign cbx = {{11{dcb1[8]}}, dcb1};
  assign crx = {{11{dcr1[8]}}, dcr1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y2  <= '0;
      ys2 <= '0;
      pr2 <= '0;
      pg2 <= '0;
      pb2 <= '0;
      c2  <= '0;
    end else begin
      y2  <= y1;
      ys2 <= $signed({4'b0, y1, 8'h80});
      pr2 <= 20'sd359 * crx;
      pg2 <= 20'sd88 * cbx + 20'sd183 * crx;
      pb2 <= 20'sd454 * cbx;
      c2  <= c1;
    end
  end

  assign sr = (ys2 + pr2) >>> 8;
  assign sg = (ys2 - pg2) >>> 8;
  assign sb = (ys2 + pb2) >>> 8;

  assign cr_r = clamp(sr);
  assign cr_g = clamp(sg);
  assign cr_b = clamp(sb);

  always_comb begin
    mr = cr_r;
    mg = cr_g;
    mb = cr_b;
    unique case (c2.m)
      2'b00: begin
        mr = cr_r;
        mg = cr_g;
        mb = cr_b;
      end
      2'b01: begin
        mr = y2;
        mg = y2;
        mb = y2;
      end
      2'b10: begin
        mr = 8'd0;
        mg = y2;
        mb = 8'd0;
      end
      2'b11: begin
        mr = y2;
        mg = {1'b0, y2[7:1]};
        mb = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro  <= '0;
      go  <= '0;
      bo  <= '0;
      vo  <= 1'b0;
      hso <= 1'b0;
      vso <= 1'b0;
    end else begin
      vo  <= c2.v;
      hso <= c2.hs;
      vso <= c2.vs;
      if (c2.v) begin
        ro <= mr;
        go <= mg;
        bo <= mb;
      end else begin
        ro <= '0;
        go <= '0;
        bo <= '0;
      end
    end
  end

endmodule
